floor_request_sched: RTL and testbench

- Request scheduler between the button one-shot stage and the elevator state machine.
- Latches floor-call pulses into a pending set and runs a SCAN (up/down sweep) policy.
- Presents one registered target floor, a travel direction and a valid flag to the state machine.
- Clears a floor's request when the car reports arrival there.

---
 rtl/elev_pkg.sv | 14 +
 rtl/floor_pick.sv | 34 +++
 rtl/floor_request_sched.sv | 138 +++++++++++++
 tb/tb_floor_request_sched.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/elev_pkg.sv
// Shared types and default sizing for the elevator request scheduler.
package elev_pkg;

    // Sweep state of the scheduler.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } sched_state_t;

    localparam int NUM_FLOORS_DEF = 3;
    localparam int FLOOR_W_DEF    = 2;

endpackage

// File: rtl/floor_pick.sv
// Combinational SCAN search: nearest pending floor above and below the car.
module floor_pick #(
    parameter int NUM_FLOORS = 3,
    parameter int FLOOR_W    = 2
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    cur_floor,
    output logic [FLOOR_W-1:0]    above,
    output logic [FLOOR_W-1:0]    below,
    output logic                  has_above,
    output logic                  has_below
);

    // Descending scan leaves the lowest floor above; ascending scan leaves the highest floor below.
    always_comb begin
        above     = '0;
        below     = '0;
        has_above = 1'b0;
        has_below = 1'b0;
        for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
            if (pending[f] && (f > int'(cur_floor))) begin
                above     = FLOOR_W'(f);
                has_above = 1'b1;
            end
        end
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (pending[f] && (f < int'(cur_floor))) begin
                below     = FLOOR_W'(f);
                has_below = 1'b1;
            end
        end
    end

endmodule

// File: rtl/floor_request_sched.sv
// Floor request scheduler: latches call pulses and selects targets with a SCAN sweep.
module floor_request_sched
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS = NUM_FLOORS_DEF,
    parameter int FLOOR_W    = FLOOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] req_pulse,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  busy,
    input  logic                  arrived,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  target_valid,
    output logic                  dir_up,
    output logic                  door_req
);

    sched_state_t          state_q, state_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [FLOOR_W-1:0]    target_floor_q, target_floor_d;
    logic                  target_valid_q, target_valid_d;
    logic                  dir_up_q, dir_up_d;
    logic                  door_req_q, door_req_d;

    logic [NUM_FLOORS-1:0] here_mask;
    logic [NUM_FLOORS-1:0] set_mask;
    logic [NUM_FLOORS-1:0] clr_mask;
    logic                  cur_in_range;
    logic                  idle_here_call;

    logic [FLOOR_W-1:0]    above, below;
    logic                  has_above, has_below;

    floor_pick #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_pick (
        .pending   (pending_q),
        .cur_floor (cur_floor),
        .above     (above),
        .below     (below),
        .has_above (has_above),
        .has_below (has_below)
    );

    // Pending-set update: calls at the current floor of an idle car open the door instead of latching; arrival clear wins over set.
    always_comb begin
        cur_in_range   = (int'(cur_floor) < NUM_FLOORS);
        here_mask      = cur_in_range ? (NUM_FLOORS'(1) << cur_floor) : '0;
        idle_here_call = (|(req_pulse & here_mask)) && (state_q == IDLE) && !busy;
        set_mask       = idle_here_call ? (req_pulse & ~here_mask) : req_pulse;
        clr_mask       = arrived ? here_mask : '0;
        pending_d      = (pending_q | set_mask) & ~clr_mask;
        door_req_d     = idle_here_call;
    end

    // SCAN next-state decision; target and direction are registered from the chosen next state.
    always_comb begin
        state_d        = state_q;
        target_floor_d = target_floor_q;
        target_valid_d = 1'b0;
        dir_up_d       = dir_up_q;

        case (state_q)
            IDLE: begin
                if (pending_q == '0) begin
                    state_d = IDLE;
                end else if (has_above && has_below) begin
                    // Tie in distance goes up.
                    state_d = ((above - cur_floor) <= (cur_floor - below)) ? UP : DOWN;
                end else if (has_above) begin
                    state_d = UP;
                end else if (has_below) begin
                    state_d = DOWN;
                end else begin
                    // Only the current-floor bit is pending while busy; it clears on arrival.
                    state_d = IDLE;
                end
            end
            UP: begin
                if (has_above)      state_d = UP;
                else if (has_below) state_d = DOWN;
                else                state_d = IDLE;
            end
            DOWN: begin
                if (has_below)      state_d = DOWN;
                else if (has_above) state_d = UP;
                else                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            UP: begin
                target_floor_d = above;
                dir_up_d       = 1'b1;
                target_valid_d = 1'b1;
            end
            DOWN: begin
                target_floor_d = below;
                dir_up_d       = 1'b0;
                target_valid_d = 1'b1;
            end
            default: begin
                target_valid_d = 1'b0;
            end
        endcase
    end

    // State, pending set and output registers; reset drops every outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            pending_q      <= '0;
            target_floor_q <= '0;
            target_valid_q <= 1'b0;
            dir_up_q       <= 1'b1;
            door_req_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            target_floor_q <= target_floor_d;
            target_valid_q <= target_valid_d;
            dir_up_q       <= dir_up_d;
            door_req_q     <= door_req_d;
        end
    end

    assign pending      = pending_q;
    assign target_floor = target_floor_q;
    assign target_valid = target_valid_q;
    assign dir_up       = dir_up_q;
    assign door_req     = door_req_q;

endmodule

// File: tb/tb_floor_request_sched.sv
// Scoreboard bench for floor_request_sched: stimulus queues expected per-cycle outputs, a monitor compares them.
module tb_floor_request_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req_pulse = '0;
    logic [1:0] cur_floor = '0;
    logic       busy = 1'b0;
    logic       arrived = 1'b0;
    logic [2:0] pending;
    logic [1:0] target_floor;
    logic       target_valid;
    logic       dir_up;
    logic       door_req;

    floor_request_sched #(
        .NUM_FLOORS (3),
        .FLOOR_W    (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_pulse    (req_pulse),
        .cur_floor    (cur_floor),
        .busy         (busy),
        .arrived      (arrived),
        .pending      (pending),
        .target_floor (target_floor),
        .target_valid (target_valid),
        .dir_up       (dir_up),
        .door_req     (door_req)
    );

    always #50 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         stamp;
        string      name;
        logic [2:0] pend;
        logic       tv;
        logic [1:0] tf;
        logic       dir;
        logic       door;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    task automatic expect_o(input string nm, input logic [2:0] p, input logic tv,
                            input logic [1:0] tf, input logic d, input logic dr);
        exp_t x;
        x.stamp = cyc;
        x.name  = nm;
        x.pend  = p;
        x.tv    = tv;
        x.tf    = tf;
        x.dir   = d;
        x.door  = dr;
        q.push_back(x);
    endtask

    // Apply pulses for one edge, then drop them.
    task automatic step(input logic [2:0] rp, input logic arr);
        req_pulse = rp;
        arrived   = arr;
        @(posedge clk);
        #1;
        req_pulse = '0;
        arrived   = 1'b0;
    endtask

    // Monitor: compare every expectation due at this cycle, mid-cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].stamp <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.stamp != cyc ||
                {pending, target_valid, target_floor, dir_up, door_req} !=
                {e.pend, e.tv, e.tf, e.dir, e.door}) begin
                errors++;
                $display("FAIL %s @cyc %0d: got pend=%b tv=%b tf=%0d dir=%b door=%b, want pend=%b tv=%b tf=%0d dir=%b door=%b",
                         e.name, cyc, pending, target_valid, target_floor, dir_up, door_req,
                         e.pend, e.tv, e.tf, e.dir, e.door);
            end
        end
    end

    initial begin
        // Reset, then idle with no calls.
        rst = 1'b1;
        step(3'b000, 1'b0);
        step(3'b000, 1'b0);
        expect_o("reset", 3'b000, 0, 2'd0, 1, 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(3'b000, 1'b0);
            expect_o("idle_hold", 3'b000, 0, 2'd0, 1, 0);
        end

        // Single call to floor 2 from floor 0, then arrival.
        cur_floor = 2'd0; busy = 1'b0;
        step(3'b100, 1'b0); expect_o("call2_pend", 3'b100, 0, 2'd0, 1, 0);
        step(3'b000, 1'b0); expect_o("call2_tgt", 3'b100, 1, 2'd2, 1, 0);
        busy = 1'b1;
        step(3'b000, 1'b0); expect_o("call2_travel", 3'b100, 1, 2'd2, 1, 0);
        cur_floor = 2'd2; busy = 1'b0;
        step(3'b000, 1'b1); expect_o("call2_arrive", 3'b000, 0, 2'd2, 1, 0);
        step(3'b000, 1'b0); expect_o("call2_idle", 3'b000, 0, 2'd2, 1, 0);

        // Mid-sweep pickup of floor 1 while heading to 2.
        cur_floor = 2'd0; busy = 1'b1;
        step(3'b100, 1'b0); expect_o("pick_pend", 3'b100, 0, 2'd2, 1, 0);
        step(3'b000, 1'b0); expect_o("pick_tgt2", 3'b100, 1, 2'd2, 1, 0);
        step(3'b010, 1'b0); expect_o("pick_pend1", 3'b110, 1, 2'd2, 1, 0);
        step(3'b000, 1'b0); expect_o("pick_retgt1", 3'b110, 1, 2'd1, 1, 0);
        cur_floor = 2'd1;
        step(3'b000, 1'b1); expect_o("pick_arr1", 3'b100, 1, 2'd2, 1, 0);
        step(3'b000, 1'b0); expect_o("pick_hold", 3'b100, 1, 2'd2, 1, 0);
        cur_floor = 2'd2;
        step(3'b000, 1'b1); expect_o("pick_arr2", 3'b000, 0, 2'd2, 1, 0);

        // Direction reversal: from floor 1 with calls at 0 and 2 (tie goes up).
        cur_floor = 2'd1; busy = 1'b0;
        step(3'b101, 1'b0); expect_o("rev_pend", 3'b101, 0, 2'd2, 1, 0);
        step(3'b000, 1'b0); expect_o("rev_tie_up", 3'b101, 1, 2'd2, 1, 0);
        busy = 1'b1; cur_floor = 2'd2;
        step(3'b000, 1'b1); expect_o("rev_down", 3'b001, 1, 2'd0, 0, 0);
        step(3'b000, 1'b0); expect_o("rev_down_hold", 3'b001, 1, 2'd0, 0, 0);
        cur_floor = 2'd0;
        step(3'b000, 1'b1); expect_o("rev_idle", 3'b000, 0, 2'd0, 0, 0);
        step(3'b000, 1'b0); expect_o("rev_idle_hold", 3'b000, 0, 2'd0, 0, 0);

        // Current-floor call while idle opens the door without latching.
        cur_floor = 2'd1; busy = 1'b0;
        step(3'b010, 1'b0); expect_o("door_pulse", 3'b000, 0, 2'd0, 0, 1);
        step(3'b000, 1'b0); expect_o("door_one_cycle", 3'b000, 0, 2'd0, 0, 0);
        // Same call while busy latches; FSM stays idle on a current-floor-only request.
        busy = 1'b1;
        step(3'b010, 1'b0); expect_o("busy_latch", 3'b010, 0, 2'd0, 0, 0);
        step(3'b010, 1'b0); expect_o("dup_idem", 3'b010, 0, 2'd0, 0, 0);
        // Out-of-range arrival is ignored; search from floor 3 sees floor 1 below.
        cur_floor = 2'd3;
        step(3'b000, 1'b1); expect_o("oor_arrive", 3'b010, 1, 2'd1, 0, 0);
        // Coincident arrival and call at floor 1: clear wins.
        cur_floor = 2'd1;
        step(3'b010, 1'b1); expect_o("clr_beats_set", 3'b000, 0, 2'd1, 0, 0);
        step(3'b000, 1'b0); expect_o("clr_hold", 3'b000, 0, 2'd1, 0, 0);

        // Reset mid-sweep, then normal scheduling resumes.
        cur_floor = 2'd2; busy = 1'b1;
        step(3'b101, 1'b0); expect_o("mr_pend", 3'b101, 0, 2'd1, 0, 0);
        step(3'b000, 1'b0); expect_o("mr_down", 3'b101, 1, 2'd0, 0, 0);
        rst = 1'b1;
        step(3'b000, 1'b0); expect_o("mr_reset", 3'b000, 0, 2'd0, 1, 0);
        rst = 1'b0; cur_floor = 2'd0; busy = 1'b0;
        step(3'b010, 1'b0); expect_o("post_pend", 3'b010, 0, 2'd0, 1, 0);
        step(3'b000, 1'b0); expect_o("post_up", 3'b010, 1, 2'd1, 1, 0);
        step(3'b110, 1'b0); expect_o("multi_latch", 3'b110, 1, 2'd1, 1, 0);
        step(3'b000, 1'b0); expect_o("multi_hold", 3'b110, 1, 2'd1, 1, 0);

        // Drain the scoreboard.
        step(3'b000, 1'b0);
        step(3'b000, 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
